// File: rtl/sram_port_arbiter.sv
// Arbiter/sequencer sharing a 512x32 1RW1R SRAM between requesters A, B (RW port) and R (read port).
// Optional macro SRAM_ARB_COLLISION_STALL_EN stalls R when it reads the address port 0 is writing.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_req_i,
  output logic                  a_gnt_o,
  input  logic                  a_we_i,
  input  logic [NUM_WMASKS-1:0] a_be_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_req_i,
  output logic                  b_gnt_o,
  input  logic                  b_we_i,
  input  logic [NUM_WMASKS-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  input  logic                  r_req_i,
  output logic                  r_gnt_o,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  output logic                  r_rvalid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  input  logic [DATA_WIDTH-1:0] sram_dout1_i
);

  typedef enum logic [1:0] {RESP_NONE, RESP_A, RESP_B} resp_e;
  typedef enum logic {PRIO_A, PRIO_B} prio_e;

  prio_e prio_q, prio_d;
  resp_e resp0_q, resp0_d;
  logic  we0_q, we0_d;
  logic  resp1_q, resp1_d;
  logic  collision;

  // Request cycle: grant decision and macro pin drive
  always_comb begin
    a_gnt_o       = 1'b0;
    b_gnt_o       = 1'b0;
    prio_d        = prio_q;
    resp0_d       = RESP_NONE;
    we0_d         = 1'b0;
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    collision     = 1'b0;
    if (rst_i) begin
      prio_d = PRIO_A;
    end else begin
      if (a_req_i && (!b_req_i || prio_q == PRIO_A)) a_gnt_o = 1'b1;
      else if (b_req_i)                              b_gnt_o = 1'b1;
      if (a_req_i && b_req_i) prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
    end
    if (a_gnt_o) begin
      resp0_d       = RESP_A;
      we0_d         = a_we_i;
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~a_we_i;
      sram_wmask0_o = a_we_i ? a_be_i : '0;
      sram_addr0_o  = a_addr_i;
      sram_din0_o   = a_wdata_i;
    end else if (b_gnt_o) begin
      resp0_d       = RESP_B;
      we0_d         = b_we_i;
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~b_we_i;
      sram_wmask0_o = b_we_i ? b_be_i : '0;
      sram_addr0_o  = b_addr_i;
      sram_din0_o   = b_wdata_i;
    end
`ifdef SRAM_ARB_COLLISION_STALL_EN
    collision = ((a_gnt_o && a_we_i && (r_addr_i == a_addr_i)) ||
                 (b_gnt_o && b_we_i && (r_addr_i == b_addr_i)));
`endif
    r_gnt_o      = !rst_i && r_req_i && !collision;
    resp1_d      = r_gnt_o;
    sram_csb1_o  = ~r_gnt_o;
    sram_addr1_o = r_gnt_o ? r_addr_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q  <= PRIO_A;
      resp0_q <= RESP_NONE;
      resp1_q <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      resp0_q <= resp0_d;
      resp1_q <= resp1_d;
    end
    we0_q <= we0_d;
  end

  // Response cycle: strobes suppressed while reset is held
  always_comb begin
    a_rvalid_o = !rst_i && (resp0_q == RESP_A);
    b_rvalid_o = !rst_i && (resp0_q == RESP_B);
    r_rvalid_o = !rst_i && resp1_q;
    a_rdata_o  = (a_rvalid_o && !we0_q) ? sram_dout0_i : '0;
    b_rdata_o  = (b_rvalid_o && !we0_q) ? sram_dout0_i : '0;
    r_rdata_o  = r_rvalid_o ? sram_dout1_i : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1RW1R macro model.
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_gnt, a_we, a_rvalid;
  logic [3:0]  a_be;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_gnt, b_we, b_rvalid;
  logic [3:0]  b_be;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        r_req, r_gnt, r_rvalid;
  logic [8:0]  r_addr;
  logic [31:0] r_rdata;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic [31:0] mem [512];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .r_req_i(r_req), .r_gnt_o(r_gnt), .r_addr_i(r_addr), .r_rvalid_o(r_rvalid), .r_rdata_o(r_rdata),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0), .sram_addr0_o(addr0),
    .sram_din0_o(din0), .sram_dout0_i(dout0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
  );

  // Macro model: one-cycle read latency, byte-masked writes
  initial for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  initial begin
    dout0 = 32'h0;
    dout1 = 32'h0;
  end
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    r_req = 0; r_addr = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    a_req = 1; r_req = 1;
    next_cycle();
    mid();
    check("rst_a_gnt", a_gnt, 0);
    check("rst_r_gnt", r_gnt, 0);
    check("rst_csb0", csb0, 1);
    check("rst_csb1", csb1, 1);
    check("rst_web0", web0, 1);

    next_cycle();
    rst = 0;
    idle_inputs();
    mid();
    check("idle_gnts", {a_gnt, b_gnt, r_gnt}, 0);
    check("idle_rvalids", {a_rvalid, b_rvalid, r_rvalid}, 0);
    check("idle_pins", {csb0, web0, csb1, wmask0}, 7'b1110000);
    check("idle_rdata", {a_rdata, b_rdata}, 0);
    check("idle_r_rdata", r_rdata, 0);

    // A write then A read of 0x005
    next_cycle();
    a_req = 1; a_we = 1; a_be = 4'b1111; a_addr = 9'h005; a_wdata = 32'hDEADBEEF;
    mid();
    check("aw_gnt", a_gnt, 1);
    check("aw_pins", {csb0, web0, wmask0, addr0}, {1'b0, 1'b0, 4'b1111, 9'h005});
    check("aw_din", din0, 32'hDEADBEEF);
    check("aw_rvalid_early", a_rvalid, 0);
    next_cycle();
    a_we = 0; a_be = 0; a_wdata = 0;
    mid();
    check("ar_gnt", a_gnt, 1);
    check("ar_wmask", {web0, wmask0}, 5'b10000);
    check("aw_rvalid", a_rvalid, 1);
    check("aw_rdata", a_rdata, 0);
    next_cycle();
    idle_inputs();
    mid();
    check("ar_rvalid", a_rvalid, 1);
    check("ar_rdata", a_rdata, 32'hDEADBEEF);
    next_cycle();
    mid();
    check("ar_rvalid_drop", a_rvalid, 0);
    check("ar_rdata_zero", a_rdata, 0);

    // Contested reads alternate A, B starting with A
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      a_req = 1; a_addr = 9'h005;
      b_req = 1; b_addr = 9'h005;
      mid();
      check($sformatf("rr_a_gnt%0d", i), a_gnt, (i % 2) == 0);
      check($sformatf("rr_b_gnt%0d", i), b_gnt, (i % 2) == 1);
      if (i > 0) begin
        check($sformatf("rr_a_rv%0d", i), a_rvalid, (i % 2) == 1);
        check($sformatf("rr_b_rv%0d", i), b_rvalid, (i % 2) == 0);
        check($sformatf("rr_a_rd%0d", i), a_rdata, ((i % 2) == 1) ? 32'hDEADBEEF : 32'h0);
        check($sformatf("rr_b_rd%0d", i), b_rdata, ((i % 2) == 0) ? 32'hDEADBEEF : 32'h0);
      end
    end
    next_cycle();
    idle_inputs();
    mid();
    check("rr_last_b_rv", {a_rvalid, b_rvalid}, 2'b01);
    check("rr_last_b_rd", b_rdata, 32'hDEADBEEF);

    // Byte-masked write over a full preload, read back through R
    next_cycle();
    b_req = 1; b_we = 1; b_be = 4'b1111; b_addr = 9'h010; b_wdata = 32'hFFFFFFFF;
    mid();
    check("pre_b_gnt", b_gnt, 1);
    next_cycle();
    idle_inputs();
    a_req = 1; a_we = 1; a_be = 4'b0101; a_addr = 9'h010; a_wdata = 32'h11223344;
    mid();
    check("mw_wmask", {csb0, web0, wmask0}, 6'b000101);
    check("pre_b_rdata", {b_rvalid, b_rdata}, {1'b1, 32'h0});
    next_cycle();
    idle_inputs();
    r_req = 1; r_addr = 9'h010;
    mid();
    check("r_gnt", r_gnt, 1);
    check("r_pins", {csb1, addr1}, {1'b0, 9'h010});
    next_cycle();
    idle_inputs();
    mid();
    check("r_rvalid", r_rvalid, 1);
    check("r_rdata_masked", r_rdata, 32'hFF22FF44);
    next_cycle();
    mid();
    check("r_rdata_idle", {r_rvalid, r_rdata}, 0);

    // Concurrent B write and non-colliding R read
    next_cycle();
    b_req = 1; b_we = 1; b_be = 4'b1111; b_addr = 9'h1FF; b_wdata = 32'hCAFEF00D;
    r_req = 1; r_addr = 9'h010;
    mid();
    check("conc_gnts", {b_gnt, r_gnt}, 2'b11);
    next_cycle();
    idle_inputs();
    mid();
    check("conc_r_rdata", r_rdata, 32'hFF22FF44);
    check("conc_b_rv", {b_rvalid, b_rdata}, {1'b1, 32'h0});

`ifdef SRAM_ARB_COLLISION_STALL_EN
    next_cycle();
    b_req = 1; b_we = 1; b_be = 4'b1111; b_addr = 9'h1FF; b_wdata = 32'h0BADCAFE;
    r_req = 1; r_addr = 9'h1FF;
    mid();
    check("col_b_gnt", b_gnt, 1);
    check("col_r_stall", {r_gnt, csb1}, 2'b01);
    next_cycle();
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    mid();
    check("col_r_retry", {r_gnt, csb1}, 2'b10);
    next_cycle();
    idle_inputs();
    mid();
    check("col_r_rdata", {r_rvalid, r_rdata}, {1'b1, 32'h0BADCAFE});
`endif

    // Reset right after an A read grant drops its response and restores A priority
    next_cycle();
    a_req = 1; a_addr = 9'h005; b_req = 1; b_addr = 9'h005;
    mid();
    check("pr_a_gnt", {a_gnt, b_gnt}, 2'b10);
    next_cycle();
    b_req = 0;
    mid();
    check("pr_a_single", a_gnt, 1);
    next_cycle();
    rst = 1; b_req = 1;
    mid();
    check("rst2_gnts", {a_gnt, b_gnt}, 0);
    check("rst2_a_rvalid", a_rvalid, 0);
    check("rst2_a_rdata", a_rdata, 0);
    check("rst2_csb0", {csb0, web0}, 2'b11);
    next_cycle();
    rst = 0;
    mid();
    check("post_rst_a_first", {a_gnt, b_gnt}, 2'b10);
    check("post_rst_no_rv", {a_rvalid, b_rvalid}, 0);
    next_cycle();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Sequencer and arbiter that shares one 512x32 1RW1R SRAM macro between two read/write requesters (A, B) on the RW port and one read-only requester (R) on the R port. It sits between the bus-side request/grant/rvalid interfaces and the macro pins, and owns all chip-select, write-enable and mask sequencing. It tracks the one-cycle read latency per port and blocks same-cycle write/read address collisions. The macro's clk0 and clk1 are both driven by clk_i outside this block.

## Interface
- ADDR_WIDTH, 9, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8)

- clk_i  input  1  sole clock; all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- a_req_i / b_req_i  input  1  request from requester A / B
- a_gnt_o / b_gnt_o  output  1  grant; combinational, same cycle as request
- a_we_i / b_we_i  input  1  1 = write, 0 = read
- a_be_i / b_be_i  input  NUM_WMASKS  byte enables for writes
- a_addr_i / b_addr_i  input  ADDR_WIDTH  word address
- a_wdata_i / b_wdata_i  input  DATA_WIDTH  write data
- a_rvalid_o / b_rvalid_o  output  1  response strobe, one cycle after grant
- a_rdata_o / b_rdata_o  output  DATA_WIDTH  read data; 0 unless rvalid and read
- r_req_i  input  1  read request on the R port
- r_gnt_o  output  1  R grant, combinational
- r_addr_i  input  ADDR_WIDTH  R word address
- r_rvalid_o  output  1  R response strobe
- r_rdata_o  output  DATA_WIDTH  R read data; 0 unless r_rvalid_o
- sram_csb0_o, sram_web0_o  output  1  macro port 0 chip select / write enable, active low
- sram_wmask0_o  output  NUM_WMASKS  macro port 0 mask
- sram_addr0_o  output  ADDR_WIDTH  macro port 0 address
- sram_din0_o  output  DATA_WIDTH  macro port 0 write data
- sram_dout0_i  input  DATA_WIDTH  macro port 0 read data
- sram_csb1_o  output  1  macro port 1 chip select, active low
- sram_addr1_o  output  ADDR_WIDTH  macro port 1 address
- sram_dout1_i  input  DATA_WIDTH  macro port 1 read data

## Operation
- Port 0 arbitration is round-robin over A and B. prio_q selects the favoured requester and resets to A.
  - Only one requesting: that one is granted.
  - Both requesting: the prio_q requester is granted, and prio_q flips to the other.
  - Single-requester grants do not change prio_q.
- Granted port 0 request: sram_csb0_o=0, sram_web0_o=~we, addr, din and be are muxed from the winner, and wmask = be on writes, 0 on reads.
- Port 0 idle: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
- Response tracker resp0_q ∈ {NONE, A, B} and we0_q are loaded every cycle from the grant decision. In the next cycle the owner's rvalid is 1.
  - On a read, rdata = sram_dout0_i.
  - On a write, rdata = 0.
- Port 1: r_gnt_o = r_req_i unless a collision stall applies. On grant, csb1=0 and addr1=r_addr_i; otherwise csb1=1 and addr1=0. The tracker resp1_q drives r_rvalid_o next cycle with r_rdata_o = sram_dout1_i.
- All rdata outputs are forced to 0 whenever their rvalid is 0.

## Timing
- Grant is combinational in the request cycle N. The macro samples at the edge ending N. The response (rvalid, rdata) is in cycle N+1. Data is valid from mid-cycle N+1 and is sampled by the consumer at the edge ending N+1.
- Back-to-back grants are allowed every cycle on both ports; throughput is one access per port per cycle.
- The requester holds req, addr, we, be and wdata stable until gnt. It may drop req without gnt; no state is affected.
- rst_i asserted in any cycle:
  - That cycle: all gnt=0, all rvalid=0, csb0=csb1=1, web0=1.
  - At the end of it: prio_q=A, resp0_q=resp1_q=NONE.
  - A request granted in the cycle before reset loses its response; the response is not replayed.
- Reset values of every output are the idle values above; all rdata outputs are 0.

## Configuration
- SRAM_ARB_COLLISION_STALL_EN defined: if port 0 grants a write in cycle N and r_req_i=1 with r_addr_i == the port 0 address, then r_gnt_o=0 and csb1=1 in N. R retries and is granted in N+1 when there is no new collision.
- SRAM_ARB_COLLISION_STALL_EN undefined: R is never stalled. A colliding read returns undefined data, and the bench must not check it.

## Test plan
- Reset, then idle: all gnt/rvalid 0, csb0=csb1=web0=1, wmask0=0, rdata 0.
- A write addr 0x005 data 0xDEADBEEF be 4'b1111, then A read 0x005 -> rvalid one cycle after each grant, write rdata 0, read rdata 0xDEADBEEF.
- A and B both request reads for 8 consecutive cycles -> grants alternate A, B, A, B…, starting with A after reset, with exactly one rvalid per grant.
- A write 0x010 be 4'b0101 data 0x11223344 over a preload of 0xFFFFFFFF, then R read 0x010 -> r_rdata_o 0xFF22FF44.
- With SRAM_ARB_COLLISION_STALL_EN: B write 0x1FF and R read 0x1FF in the same cycle -> r_gnt_o 0 that cycle, 1 next cycle, r_rdata_o returns the new data.
- Assert rst_i in the cycle after an A read grant -> a_rvalid_o stays 0, and the next post-reset grant goes to A.
